tdm_mux_scan: RTL

- Parametrised, registered N:1 multiplexer of WIDTH-bit channels.
- Two modes:
  - Manual: the channel is chosen by the sel input, one cycle of latency.
  - Scan: time-division; the block steps through the channels automatically, holding each for a programmable number of cycles.
- Feeds display, serial and sampling blocks that need one shared data path for many sources.
- Successor to the combinational 4:1 mux: adds generic width and channel count, registered outputs, a channel tag, valid and frame strobes.

---
 rtl/tdm_mux_scan.sv | 106 ++++++++++
 1 files changed

// File: rtl/tdm_mux_scan.sv
// tdm_mux_scan: registered N:1 channel mux with manual select and timed round-robin scan.
// Define MUX_SKIP_MASKED_EN to make scan and manual select honour the channel mask.
module tdm_mux_scan #(
  parameter int WIDTH = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL_W = 8,
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      start,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          z,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      frame
);
  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);
  state_t state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_eff;
  logic [WIDTH-1:0] dv [CHANNELS];
  logic [WIDTH-1:0] z_n;
  logic [SEL_W-1:0] ch_n, nxt, first;
  logic valid_n, frame_n, wrap, any, sel_ok;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign dv[i] = d[i*WIDTH +: WIDTH];
  end
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
`ifdef MUX_SKIP_MASKED_EN
  // descending search so the lowest qualifying index wins
  always_comb begin
    nxt = '0;
    first = ch;
    wrap = 1'b1;
    any = |mask;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
      if (mask[i] && i > int'(ch)) begin
        nxt = SEL_W'(i);
        wrap = 1'b0;
      end
    end
    nxt = wrap ? first : nxt;
  end
  assign sel_ok = ({1'b0, sel} < NCH) && mask[sel];
`else
  logic unused_mask;
  assign unused_mask = ^mask;
  assign any = 1'b1;
  assign first = '0;
  assign wrap = (ch == LAST);
  assign nxt = wrap ? '0 : ch + SEL_W'(1);
  assign sel_ok = {1'b0, sel} < NCH;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    z_n = '0;
    ch_n = ch;
    valid_n = 1'b0;
    frame_n = 1'b0;
    if (!mode) begin
      state_n = MANUAL;
      z_n = sel_ok ? dv[sel] : '0;
      ch_n = sel_ok ? sel : ch;
      valid_n = sel_ok;
    end else if (state == MANUAL) begin
      state_n = IDLE;
    end else if (start) begin
      state_n = SCAN;
      cnt_n = dwell_eff;
      ch_n = first;
      z_n = any ? dv[first] : '0;
      valid_n = any;
    end else if (state == SCAN && any) begin
      cnt_n = (cnt == DWELL_W'(1)) ? dwell_eff : cnt - DWELL_W'(1);
      ch_n = (cnt == DWELL_W'(1)) ? nxt : ch;
      frame_n = (cnt == DWELL_W'(1)) && wrap;
      z_n = dv[ch_n];
      valid_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      z <= '0;
      ch <= '0;
      valid <= 1'b0;
      frame <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      z <= z_n;
      ch <= ch_n;
      valid <= valid_n;
      frame <= frame_n;
    end
  end
endmodule
